// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the execute stage.
// Multiply: radix-2^MUL_STEP shift-add on operand magnitudes, sign applied to the
// full 2*DATA_WIDTH product. Divide: radix-2 restoring on magnitudes with the
// quotient/remainder sign fix folded into the final iteration.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds valid and its payload stable until that edge.
// The unit holds out_valid/out_result/out_tag stable until out_ready is seen.
module mdu_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_STEP   = 4,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_src1,
    input  logic [DATA_WIDTH-1:0] in_src2,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  busy,
    output logic [1:0]            o_dbg_state
);

    localparam int W          = DATA_WIDTH;
    localparam int PW         = 2 * DATA_WIDTH;
    localparam int MUL_CYCLES = DATA_WIDTH / MUL_STEP;
    localparam int CW         = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]           r_op;
    logic [W-1:0]         r_src1;
    logic [W-1:0]         r_src2;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [W-1:0]         r_result;
    logic [CW-1:0]        r_cnt;

    // multiplier datapath
    logic [PW-1:0] r_mcand;
    logic [W-1:0]  r_mplier;
    logic [PW-1:0] r_acc;
    logic          r_mneg;

    // divider datapath
    logic [W-1:0] r_quo;
    logic [W-1:0] r_rem;
    logic [W-1:0] r_dvs;
    logic         r_qneg;
    logic         r_rneg;

    // Two's complement magnitude when the operand is treated as signed.
    function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
        return (s && v[W-1]) ? (~v + 1'b1) : v;
    endfunction

    logic          w_accept;
    logic          w_in_mul_signed;
    logic          w_div_signed;
    logic          w_dvs_zero;
    logic [PW-1:0] w_pp;
    logic [PW-1:0] w_acc_nxt;
    logic [PW-1:0] w_prod;
    logic [W-1:0]  w_mul_res;
    logic [W:0]    w_trial;
    logic          w_fits;
    logic [W-1:0]  w_quo_nxt;
    logic [W-1:0]  w_rem_nxt;
    logic [W-1:0]  w_q_fix;
    logic [W-1:0]  w_r_fix;
    logic [W-1:0]  w_div_res;
    logic [W-1:0]  w_dz_res;

    assign w_accept        = (r_state == S_IDLE) && in_valid && !flush;
    // MULHU is the only unsigned multiply; MUL/reserved share low bits either way.
    assign w_in_mul_signed = (in_op[1:0] != 2'b10);
    assign w_div_signed    = ~r_op[1];
    assign w_dvs_zero      = (r_src2 == '0);

    assign w_pp      = r_mcand * {{(PW - MUL_STEP){1'b0}}, r_mplier[MUL_STEP-1:0]};
    assign w_acc_nxt = r_acc + w_pp;
    assign w_prod    = r_mneg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
    assign w_mul_res = (r_op[1:0] == 2'b01 || r_op[1:0] == 2'b10) ? w_prod[PW-1:W]
                                                                  : w_prod[W-1:0];

    // Restoring step: shift the next dividend bit into the partial remainder
    // and keep the subtraction only when it does not borrow.
    assign w_trial   = {r_rem, r_quo[W-1]} - {1'b0, r_dvs};
    assign w_fits    = ~w_trial[W];
    assign w_rem_nxt = w_fits ? w_trial[W-1:0] : {r_rem[W-2:0], r_quo[W-1]};
    assign w_quo_nxt = {r_quo[W-2:0], w_fits};
    assign w_q_fix   = r_qneg ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    assign w_r_fix   = r_rneg ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    assign w_div_res = r_op[0] ? w_r_fix : w_q_fix;
    // Divide by zero: quotient all ones, remainder is the raw dividend.
    assign w_dz_res  = r_op[0] ? r_src1 : '1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs; flush always returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept) w_state_nxt = in_op[2] ? S_DIV : S_MUL;
            end
            S_MUL: begin
                if (r_cnt == MUL_LAST) w_state_nxt = S_DONE;
            end
            S_DIV: begin
                // The first DIV cycle prepares magnitudes; a zero divisor
                // bypasses the iterations from there.
                if ((r_cnt == '0 && w_dvs_zero) || r_cnt == DIV_LAST) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    // Operand capture, multiply/divide iterations and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_tag    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_mneg   <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
        end else if (w_accept) begin
            r_op     <= in_op;
            r_src1   <= in_src1;
            r_src2   <= in_src2;
            r_tag    <= in_tag;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, mag(in_src1, w_in_mul_signed)};
            r_mplier <= mag(in_src2, w_in_mul_signed);
            r_mneg   <= w_in_mul_signed && (in_src1[W-1] ^ in_src2[W-1]);
        end else if (r_state == S_MUL && !flush) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << MUL_STEP;
            r_mplier <= r_mplier >> MUL_STEP;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == MUL_LAST) r_result <= w_mul_res;
        end else if (r_state == S_DIV && !flush) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '0) begin
                if (w_dvs_zero) r_result <= w_dz_res;
                r_quo  <= mag(r_src1, w_div_signed);
                r_dvs  <= mag(r_src2, w_div_signed);
                r_rem  <= '0;
                r_qneg <= w_div_signed && (r_src1[W-1] ^ r_src2[W-1]);
                r_rneg <= w_div_signed && r_src1[W-1];
            end else begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
                if (r_cnt == DIV_LAST) r_result <= w_div_res;
            end
        end
    end

    assign out_result  = r_result;
    assign out_tag     = r_tag;
    assign o_dbg_state = r_state;

endmodule
